pb_step_conditioner: RTL and testbench
======================================

Name: pb_step_conditioner

Overview:
- Input conditioning stage between raw pushbuttons and the button-clocked state-machine stage.
- Per channel: synchronizes an asynchronous, bouncing button to hz100, debounces it, and produces a clean one-cycle press pulse, a one-cycle release pulse and a debounced level.
- Optional auto-repeat re-fires press while the button is held.
- Downstream consumes press[0] as the step strobe and press[1] as the init strobe.

Parameters:
- NCH, 2, number of independent button channels (1..8).
- DEBOUNCE, 5, consecutive stable samples required to accept a press or release (1..255; 5 = 50 ms at 100 Hz).
- REPEAT_EN, 0, 1 enables auto-repeat of press while held.
- REPEAT_DELAY, 50, cycles in HELD before the first repeat pulse (1..255).
- REPEAT_PERIOD, 10, cycles between subsequent repeat pulses (1..255).

Ports:
- hz100  input  1  system clock, 100 Hz, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pb_raw  input  NCH  raw asynchronous button levels, 1 = pressed.
- press  output  NCH  one-cycle pulse per accepted press or repeat.
- release  output  NCH  one-cycle pulse per accepted release.
- level  output  NCH  debounced button state.

Behaviour:
- Reset: asynchronous while reset_n = 0. All synchronizer flops 0, all channels IDLE, all counters 0, and press/release/level = 0. Release of reset is synchronous to hz100.
- Synchronizer: two flops per channel; s = second-stage output. The FSM acts on s only.
- Per-channel FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Counter cnt is 8 bits. "Sample" means one rising edge of hz100.
- IDLE (level = 0):
  - s = 1: cnt <= 1, go to PRESS_WAIT.
  - If DEBOUNCE = 1, go directly to HELD with a press pulse.
- PRESS_WAIT (level = 0):
  - s = 0: go to IDLE. No pulse.
  - s = 1 and cnt = DEBOUNCE-1: go to HELD, press = 1 for the next cycle, rcnt <= 0.
  - Otherwise cnt++.
- HELD (level = 1):
  - s = 0: cnt <= 1, go to RELEASE_WAIT. If DEBOUNCE = 1, go directly to IDLE with a release pulse.
  - s = 1 with REPEAT_EN = 1: rcnt++ each cycle.
  - First repeat press fires when REPEAT_DELAY cycles have elapsed since HELD entry.
  - Later repeats fire every REPEAT_PERIOD cycles after that. rcnt reloads and never overflows.
- RELEASE_WAIT (level = 1):
  - s = 1: go to HELD. No pulse. rcnt resumes from its frozen value.
  - s = 0 and cnt = DEBOUNCE-1: go to IDLE, release = 1 for the next cycle.
  - Otherwise cnt++.
  - rcnt is frozen in this state.
- Latency: edge 1 is the first hz100 edge that samples raw = 1. press is high for exactly the cycle following edge DEBOUNCE+2. Release latency is symmetric.
- Pulses:
  - press and release are registered and exactly one cycle wide.
  - They are never both high on the same channel in the same cycle.
  - level changes on the same edge that raises press or release.
- Glitches: bounces or glitches shorter than DEBOUNCE samples produce no pulse and no level change.
- Channel independence: channels are fully independent. Simultaneous presses on several channels give simultaneous pulses.
- Reset mid-operation: returns every channel to IDLE immediately and truncates any pulse in flight. A button still held after reset_n rises is treated as a new press: debounce runs, then press fires.
- Outputs: no combinational path from pb_raw to any output.

Test Plan:
- Reset state: reset_n = 0 with pb_raw = 2'b11 -> press, release, level all 0. Release reset with pb_raw held -> press[0] and press[1] both pulse on the cycle after edge 7, and level = 2'b11.
- Clean press: DEBOUNCE = 5, pb_raw[0] rises and is held 20 cycles -> single press[0] pulse after edge 7, level[0] = 1. Drop pb_raw[0] -> single release[0] pulse 7 edges later, then level[0] = 0.
- Bounce reject: pb_raw[0] toggles 1,1,0,1,1,1,0 (all under 5 stable samples) -> no press, level stays 0. Then held for 5+ samples -> exactly one press.
- Release glitch: while HELD, pb_raw[0] drops for 3 cycles, then returns -> no release pulse, level[0] stays 1.
- Auto-repeat: REPEAT_EN = 1, delay 50, period 10, button held 100 cycles after acceptance -> press pulses at HELD entry +0, +50, +60, +70, +80, +90. Release gives one release pulse.
- Reset mid-debounce: assert reset_n = 0 at PRESS_WAIT cnt = 3 -> outputs 0 immediately. After reset, the full DEBOUNCE count restarts from 1.

Source files
------------

// File: rtl/pb_step_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pb_step_conditioner
// Purpose  : Conditions raw pushbuttons for the button-clocked state machine.
//            Each channel is synchronized to hz100, debounced, and turned
//            into a one-cycle press pulse, a one-cycle release pulse and a
//            clean debounced level. Optional auto-repeat re-fires press
//            while a button stays held.
// Ports    : hz100          - 100 Hz system clock, rising edge
//            reset_n        - asynchronous active-low reset
//            pb_raw[NCH]    - raw asynchronous button levels, 1 = pressed
//            press[NCH]     - one-cycle pulse per accepted press or repeat
//            release_pulse[NCH] - one-cycle pulse per accepted release
//                             (release is a reserved word in SystemVerilog)
//            level[NCH]     - debounced button state
// Revision : 1.0 - initial release
// ============================================================================
module pb_step_conditioner #(
  parameter int NCH           = 2,
  parameter int DEBOUNCE      = 5,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic           hz100,
  input  logic           reset_n,
  input  logic [NCH-1:0] pb_raw,
  output logic [NCH-1:0] press,
  output logic [NCH-1:0] release_pulse,
  output logic [NCH-1:0] level
);

  // Terminal values of the 8-bit counters. The debounce counter reaches
  // DEBOUNCE-1 on the DEBOUNCE-th consecutive stable sample because the
  // first stable sample loads it with 1.
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [7:0] DLY_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] PER_LAST = 8'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Two-flop synchronizer; the FSMs only ever look at the second stage.
  logic [NCH-1:0] sync_q1;
  logic [NCH-1:0] sync_q2;

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pb_raw;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rcnt_q, rcnt_d;
    logic       rptd_q, rptd_d;   // first repeat already fired in this hold
    logic       press_q, press_d;
    logic       rel_q, rel_d;
    logic       level_q, level_d;
    logic       s;

    assign s = sync_q2[ch];

    always_ff @(posedge hz100 or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= 8'd0;
        rcnt_q  <= 8'd0;
        rptd_q  <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        rptd_q  <= rptd_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        level_q <= level_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      rptd_d  = rptd_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      level_d = level_q;

      case (state_q)
        ST_IDLE: begin
          if (s) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_HELD;
              press_d = 1'b1;
              level_d = 1'b1;
              rcnt_d  = 8'd0;
              rptd_d  = 1'b0;
            end else begin
              state_d = ST_PRESS_WAIT;
              cnt_d   = 8'd1;
            end
          end
        end

        ST_PRESS_WAIT: begin
          if (!s) begin
            state_d = ST_IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_HELD;
            press_d = 1'b1;
            level_d = 1'b1;
            rcnt_d  = 8'd0;
            rptd_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        ST_HELD: begin
          if (!s) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_IDLE;
              rel_d   = 1'b1;
              level_d = 1'b0;
            end else begin
              state_d = ST_RELEASE_WAIT;
              cnt_d   = 8'd1;
            end
          end else if (REPEAT_EN != 0) begin
            // rcnt counts cycles since HELD entry (or since the last
            // repeat); it is reloaded on every fire so it cannot overflow.
            if (rcnt_q == (rptd_q ? PER_LAST : DLY_LAST)) begin
              press_d = 1'b1;
              rcnt_d  = 8'd0;
              rptd_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 8'd1;
            end
          end
        end

        ST_RELEASE_WAIT: begin
          // rcnt/rptd are untouched here, so a rejected release glitch
          // resumes the repeat schedule where it left off.
          if (s) begin
            state_d = ST_HELD;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_IDLE;
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    assign press[ch]         = press_q;
    assign release_pulse[ch] = rel_q;
    assign level[ch]         = level_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pb_step_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_step_conditioner
// Purpose  : Scoreboard bench for pb_step_conditioner. One instance uses the
//            default parameters (2 channels, no repeat); a second 1-channel
//            instance has auto-repeat enabled. Stimulus pushes expected
//            pulses (instance, channel, kind, cycle) into a queue; a monitor
//            matches every observed pulse against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_step_conditioner;

  localparam int KIND_PRESS = 0;
  localparam int KIND_REL   = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] pb;
  logic [1:0] m_press, m_rel, m_level;
  logic [0:0] pb_r;
  logic [0:0] r_press, r_rel, r_level;

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  typedef struct {
    int inst;
    int ch;
    int kind;
    int cyc;
  } exp_t;

  exp_t sb[$];

  pb_step_conditioner #(
    .NCH(2), .DEBOUNCE(5), .REPEAT_EN(0), .REPEAT_DELAY(50), .REPEAT_PERIOD(10)
  ) dut (
    .hz100(clk), .reset_n(reset_n), .pb_raw(pb),
    .press(m_press), .release_pulse(m_rel), .level(m_level)
  );

  pb_step_conditioner #(
    .NCH(1), .DEBOUNCE(5), .REPEAT_EN(1), .REPEAT_DELAY(50), .REPEAT_PERIOD(10)
  ) dut_rep (
    .hz100(clk), .reset_n(reset_n), .pb_raw(pb_r),
    .press(r_press), .release_pulse(r_rel), .level(r_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int inst, input int ch, input int kind, input int c);
    exp_t e;
    e.inst = inst;
    e.ch   = ch;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, got, exp);
    end
  endtask

  // Match an observed pulse against the earliest queued expectation of the
  // same instance/channel/kind, then check the level that accompanies it.
  task automatic match(input int inst, input int ch, input int kind,
                       input int lvl, input int exp_lvl);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].inst == inst && sb[i].ch == ch && sb[i].kind == kind)
        idx = i;
    tests++;
    if (idx < 0) begin
      failed++;
      $display("FAIL unexpected_pulse inst=%0d ch=%0d kind=%0d: pulse at cyc %0d, required none",
               inst, ch, kind, cyc);
    end else begin
      if (sb[idx].cyc != cyc) begin
        failed++;
        $display("FAIL pulse_time inst=%0d ch=%0d kind=%0d: got cyc %0d, required cyc %0d",
                 inst, ch, kind, cyc, sb[idx].cyc);
      end
      sb.delete(idx);
    end
    chk($sformatf("level_with_pulse inst=%0d ch=%0d kind=%0d", inst, ch, kind), lvl, exp_lvl);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (m_press[c] || m_rel[c])
        chk($sformatf("press_and_release_exclusive ch=%0d", c),
            int'(m_press[c] && m_rel[c]), 0);
      if (m_press[c]) match(0, c, KIND_PRESS, int'(m_level[c]), 1);
      if (m_rel[c])   match(0, c, KIND_REL,   int'(m_level[c]), 0);
    end
    if (r_press[0] || r_rel[0])
      chk("rep_press_and_release_exclusive", int'(r_press[0] && r_rel[0]), 0);
    if (r_press[0]) match(1, 0, KIND_PRESS, int'(r_level[0]), 1);
    if (r_rel[0])   match(1, 0, KIND_REL,   int'(r_level[0]), 0);
  end

  initial begin
    logic seq [7];
    int e;
    seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state with both buttons held.
    reset_n = 1'b0;
    pb      = 2'b11;
    pb_r    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_press",   int'(m_press), 0);
    chk("reset_release", int'(m_rel),   0);
    chk("reset_level",   int'(m_level), 0);
    chk("reset_rep_level", int'(r_level), 0);

    // Release reset with buttons held: both press after edge 7.
    @(negedge clk);
    reset_n = 1'b1;
    push(0, 0, KIND_PRESS, cyc + 7);
    push(0, 1, KIND_PRESS, cyc + 7);
    repeat (10) @(negedge clk);
    chk("held_through_reset_level", int'(m_level), 3);
    pb = 2'b00;
    push(0, 0, KIND_REL, cyc + 7);
    push(0, 1, KIND_REL, cyc + 7);
    repeat (10) @(negedge clk);
    chk("both_released_level", int'(m_level), 0);

    // Clean press / release on channel 0.
    pb[0] = 1'b1;
    push(0, 0, KIND_PRESS, cyc + 7);
    repeat (20) @(negedge clk);
    chk("clean_press_level", int'(m_level[0]), 1);
    pb[0] = 1'b0;
    push(0, 0, KIND_REL, cyc + 7);
    repeat (10) @(negedge clk);
    chk("clean_release_level", int'(m_level[0]), 0);

    // Bounce rejection, then a stable hold.
    for (int i = 0; i < 7; i++) begin
      pb[0] = seq[i];
      @(negedge clk);
    end
    chk("bounce_level", int'(m_level[0]), 0);
    pb[0] = 1'b1;
    push(0, 0, KIND_PRESS, cyc + 7);
    repeat (12) @(negedge clk);
    chk("after_bounce_level", int'(m_level[0]), 1);

    // Release glitch of 3 samples while held.
    pb[0] = 1'b0;
    repeat (3) @(negedge clk);
    pb[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("release_glitch_level", int'(m_level[0]), 1);
    pb[0] = 1'b0;
    push(0, 0, KIND_REL, cyc + 7);
    repeat (10) @(negedge clk);

    // Auto-repeat: HELD entry +0, +50, +60, +70, +80, +90.
    pb_r[0] = 1'b1;
    e = cyc + 7;
    push(1, 0, KIND_PRESS, e);
    for (int k = 50; k <= 90; k += 10) push(1, 0, KIND_PRESS, e + k);
    repeat (102) @(negedge clk);
    chk("repeat_held_level", int'(r_level[0]), 1);
    pb_r[0] = 1'b0;
    push(1, 0, KIND_REL, cyc + 7);
    repeat (10) @(negedge clk);
    chk("repeat_released_level", int'(r_level[0]), 0);

    // Reset mid-debounce: ch1 held, ch0 at PRESS_WAIT cnt = 3.
    pb[1] = 1'b1;
    push(0, 1, KIND_PRESS, cyc + 7);
    repeat (10) @(negedge clk);
    chk("premid_level", int'(m_level), 2);
    pb[0] = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_level",   int'(m_level), 0);
    chk("midreset_press",   int'(m_press), 0);
    chk("midreset_release", int'(m_rel),   0);
    @(negedge clk);
    reset_n = 1'b1;
    push(0, 0, KIND_PRESS, cyc + 7);
    push(0, 1, KIND_PRESS, cyc + 7);
    repeat (6) @(negedge clk);
    chk("restart_level_before", int'(m_level), 0);
    @(negedge clk);
    chk("restart_level_after", int'(m_level), 3);
    pb = 2'b00;
    push(0, 0, KIND_REL, cyc + 7);
    push(0, 1, KIND_REL, cyc + 7);
    repeat (12) @(negedge clk);
    chk("final_level", int'(m_level), 0);

    repeat (5) @(negedge clk);
    chk("missing_pulses", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
